// File: rtl/hazard_ctrl_if.sv
// Hazard unit bundle: pipeline register addresses/enables in, stall/flush/fwd out.
// Stats ports exist only when HAZARD_STATS_EN is defined.
interface hazard_ctrl_if;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic [4:0] e_rs;
  logic [4:0] e_rt;
  logic [4:0] e_rf_wa;
  logic [4:0] m_rf_wa;
  logic [4:0] w_rf_wa;
  logic       e_rf_we;
  logic       m_rf_we;
  logic       w_rf_we;
  logic       e_is_load;
  logic       e_branch_taken;
  logic       e_mdu_start;
  logic       e_mdu_div;
  logic       stall_f;
  logic       stall_d;
  logic       stall_e;
  logic       flush_d;
  logic       flush_e;
  logic       flush_m;
  logic [1:0] fwd_a_e;
  logic [1:0] fwd_b_e;
  logic       mdu_busy;
  logic       mdu_done;
`ifdef HAZARD_STATS_EN
  logic [31:0] stat_stall_cycles;
  logic [31:0] stat_flush_events;
`endif

  modport master (
    output d_rs, d_rt, e_rs, e_rt,
    output e_rf_wa, m_rf_wa, w_rf_wa,
    output e_rf_we, m_rf_we, w_rf_we,
    output e_is_load, e_branch_taken,
    output e_mdu_start, e_mdu_div,
    input  stall_f, stall_d, stall_e,
    input  flush_d, flush_e, flush_m,
    input  fwd_a_e, fwd_b_e,
`ifdef HAZARD_STATS_EN
    input  stat_stall_cycles,
    input  stat_flush_events,
`endif
    input  mdu_busy, mdu_done
  );

  modport slave (
    input  d_rs, d_rt, e_rs, e_rt,
    input  e_rf_wa, m_rf_wa, w_rf_wa,
    input  e_rf_we, m_rf_we, w_rf_we,
    input  e_is_load, e_branch_taken,
    input  e_mdu_start, e_mdu_div,
    output stall_f, stall_d, stall_e,
    output flush_d, flush_e, flush_m,
    output fwd_a_e, fwd_b_e,
`ifdef HAZARD_STATS_EN
    output stat_stall_cycles,
    output stat_flush_events,
`endif
    output mdu_busy, mdu_done
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding, load-use stall, branch flush, MDU stall FSM.
// Optional HAZARD_STATS_EN adds saturating stall/flush event counters.
module hazard_ctrl (
  input  logic           clock,
  input  logic           reset,
  hazard_ctrl_if.slave   hz
);

  typedef enum logic {
    IDLE,
    BUSY
  } mdu_state_e;

  mdu_state_e state_q, state_d;
  logic [4:0] mdu_cnt_q, mdu_cnt_d;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       m_we,
    input logic [4:0] m_wa,
    input logic       w_we,
    input logic [4:0] w_wa
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (m_we && m_wa != 5'd0 && m_wa == src)
      sel = 2'b10;
    else if (w_we && w_wa != 5'd0 && w_wa == src)
      sel = 2'b01;
    return sel;
  endfunction

  assign hz.fwd_a_e = fwd_sel(hz.e_rs,
    hz.m_rf_we, hz.m_rf_wa, hz.w_rf_we, hz.w_rf_wa);
  assign hz.fwd_b_e = fwd_sel(hz.e_rt,
    hz.m_rf_we, hz.m_rf_wa, hz.w_rf_we, hz.w_rf_wa);

  logic busy;
  logic load_use;
  logic br;

  assign busy = (state_q == BUSY);
  assign br   = hz.e_branch_taken;

  assign load_use = hz.e_is_load && hz.e_rf_we &&
    (hz.e_rf_wa != 5'd0) &&
    ((hz.e_rf_wa == hz.d_rs) || (hz.e_rf_wa == hz.d_rt));

  logic sf, sd, se, fd, fe, fm;

  // Reset gates the input-driven terms so everything but fwd reads 0.
  always_comb begin
    sf = 1'b0;
    sd = 1'b0;
    se = 1'b0;
    fd = 1'b0;
    fe = 1'b0;
    fm = 1'b0;
    if (reset) begin
      if (busy) begin
        sf = 1'b1;
        sd = 1'b1;
        se = 1'b1;
        fm = 1'b1;
      end else if (load_use && !br) begin
        sf = 1'b1;
        sd = 1'b1;
        fe = 1'b1;
      end
      if (br) begin
        fd = 1'b1;
        fe = 1'b1;
        if (!busy) begin
          sf = 1'b0;
          sd = 1'b0;
        end
      end
    end
  end

  assign hz.stall_f  = sf;
  assign hz.stall_d  = sd;
  assign hz.stall_e  = se;
  assign hz.flush_d  = fd;
  assign hz.flush_e  = fe;
  assign hz.flush_m  = fm;
  assign hz.mdu_busy = busy;
  assign hz.mdu_done = busy && (mdu_cnt_q == 5'd0);

  always_comb begin
    state_d   = state_q;
    mdu_cnt_d = mdu_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (hz.e_mdu_start) begin
          state_d   = BUSY;
          mdu_cnt_d = hz.e_mdu_div ? 5'd31 : 5'd3;
        end
      end
      BUSY: begin
        if (mdu_cnt_q == 5'd0)
          state_d = IDLE;
        else
          mdu_cnt_d = mdu_cnt_q - 5'd1;
      end
      default: begin
        state_d   = IDLE;
        mdu_cnt_d = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      mdu_cnt_q <= 5'd0;
    end else begin
      state_q   <= state_d;
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (sf && !(&stall_cnt_q))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if ((fd || fe) && !(&flush_cnt_q))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign hz.stat_stall_cycles = stall_cnt_q;
  assign hz.stat_flush_events = flush_cnt_q;
`endif

endmodule
